// File: rtl/fifo_write_sequencer.sv
// rtl/fifo_write_sequencer.sv - ADC-to-FIFO write sequencer: dav alignment, periodic NCH-word frames, burst/continuous runs
module fifo_write_sequencer #(
    parameter int CNT_W     = 16,
    parameter int BURST_W   = 16,
    parameter int NCH       = 2,
    parameter int SYNC_STG  = 2,
    parameter int LOW_CYC   = 2,
    parameter int ALIGN_DLY = 2,
    localparam int CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic               clk_in_2x,
    input  logic               rst_n,
    input  logic               adc_dav,
    input  logic               cfg_we,
    input  logic [CNT_W-1:0]   cfg_period,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic               arm,
    input  logic               fifo_full,
    output logic               fifo_write,
    output logic [CH_W-1:0]    fifo_chan,
    output logic               busy,
    output logic               done,
    output logic               overflow,
    output logic [BURST_W-1:0] frame_cnt
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SYNC_LOW  = 3'd1;
    localparam logic [2:0] S_SYNC_EDGE = 3'd2;
    localparam logic [2:0] S_ALIGN     = 3'd3;
    localparam logic [2:0] S_COUNT     = 3'd4;
    localparam logic [2:0] S_WRITE     = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;

    localparam int LC_W = $clog2(LOW_CYC + 1);
    localparam int AL_W = (ALIGN_DLY > 1) ? $clog2(ALIGN_DLY) : 1;
    localparam logic [CNT_W-1:0] MIN_PER = CNT_W'(NCH + 1);

    logic [SYNC_STG-1:0] sync_q, sync_d;
    logic                dav_d_q;
    logic                dav_s, dav_rise;
    logic [2:0]          state_q, state_d;
    logic [LC_W-1:0]     low_cnt_q, low_cnt_d;
    logic [AL_W-1:0]     align_cnt_q, align_cnt_d;
    logic [CNT_W-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0]    period_q, period_d;
    logic [BURST_W-1:0]  burst_q, burst_d;
    logic [BURST_W-1:0]  frame_cnt_q, frame_cnt_d, frame_inc;
    logic [CH_W-1:0]     chan_q, chan_d;
    logic                overflow_q, overflow_d;
    logic                last_chan;

    assign sync_d    = {sync_q[SYNC_STG-2:0], adc_dav};
    assign dav_s     = sync_q[SYNC_STG-1];
    assign dav_rise  = dav_s & ~dav_d_q;
    assign frame_inc = frame_cnt_q + 1'b1;
    assign last_chan = (chan_q == CH_W'(NCH - 1));

    always_comb begin
        state_d     = state_q;
        low_cnt_d   = low_cnt_q;
        align_cnt_d = align_cnt_q;
        timer_d     = timer_q;
        period_d    = period_q;
        burst_d     = burst_q;
        frame_cnt_d = frame_cnt_q;
        chan_d      = '0;
        overflow_d  = overflow_q;

        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_d     = S_SYNC_LOW;
                    low_cnt_d   = '0;
                    frame_cnt_d = '0;
                end
            end
            S_SYNC_LOW: begin
                if (dav_s) begin
                    low_cnt_d = '0;
                end else if (low_cnt_q == LC_W'(LOW_CYC - 1)) begin
                    state_d = S_SYNC_EDGE;
                end else begin
                    low_cnt_d = low_cnt_q + 1'b1;
                end
            end
            S_SYNC_EDGE: begin
                if (dav_rise) begin
                    if (ALIGN_DLY == 0) begin
                        state_d = S_COUNT;
                        timer_d = period_q - 1'b1;
                    end else begin
                        state_d     = S_ALIGN;
                        align_cnt_d = '0;
                    end
                end
            end
            S_ALIGN: begin
                if (align_cnt_q == AL_W'(ALIGN_DLY - 1)) begin
                    state_d = S_COUNT;
                    timer_d = period_q - 1'b1;
                end else begin
                    align_cnt_d = align_cnt_q + 1'b1;
                end
            end
            S_COUNT: begin
                if (timer_q == '0) begin
                    timer_d = period_q - 1'b1;
                    state_d = S_WRITE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_WRITE: begin
                // timer free-runs through the frame so frame starts stay period_q apart
                timer_d = timer_q - 1'b1;
                if (fifo_full) begin
                    overflow_d = 1'b1;
                end
                if (last_chan) begin
                    frame_cnt_d = frame_inc;
                    state_d     = ((burst_q != '0) && (frame_inc == burst_q)) ? S_DONE : S_COUNT;
                end else begin
                    chan_d = chan_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // reconfiguration aborts any run; a partially written frame is never counted
        if (cfg_we) begin
            state_d     = S_IDLE;
            chan_d      = '0;
            frame_cnt_d = frame_cnt_q;
            overflow_d  = 1'b0;
            period_d    = (cfg_period < MIN_PER) ? MIN_PER : cfg_period;
            burst_d     = cfg_burst;
        end
    end

    always_ff @(posedge clk_in_2x or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            dav_d_q     <= 1'b0;
            state_q     <= S_IDLE;
            low_cnt_q   <= '0;
            align_cnt_q <= '0;
            timer_q     <= '0;
            period_q    <= MIN_PER;
            burst_q     <= '0;
            frame_cnt_q <= '0;
            chan_q      <= '0;
            overflow_q  <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            dav_d_q     <= dav_s;
            state_q     <= state_d;
            low_cnt_q   <= low_cnt_d;
            align_cnt_q <= align_cnt_d;
            timer_q     <= timer_d;
            period_q    <= period_d;
            burst_q     <= burst_d;
            frame_cnt_q <= frame_cnt_d;
            chan_q      <= chan_d;
            overflow_q  <= overflow_d;
        end
    end

    assign fifo_write = (state_q == S_WRITE) & ~fifo_full;
    assign fifo_chan  = chan_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign overflow   = overflow_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_fifo_write_sequencer.sv
// tb/tb_fifo_write_sequencer.sv - randomized bench for fifo_write_sequencer against a frame-schedule model
module tb_fifo_write_sequencer;

    localparam int SYNC_STG  = 2;
    localparam int ALIGN_DLY = 2;
    localparam int MAXC      = 16384;

    logic        clk_in_2x = 1'b0;
    logic        rst_n;
    logic        adc_dav;
    logic        cfg_we;
    logic [15:0] cfg_period;
    logic [15:0] cfg_burst;
    logic        arm;
    logic        fifo_full;

    logic        f2_write, f2_busy, f2_done, f2_ovf;
    logic [0:0]  f2_chan;
    logic [15:0] f2_fc;
    logic        f4_write, f4_busy, f4_done, f4_ovf;
    logic [1:0]  f4_chan;
    logic [15:0] f4_fc;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    bit m2_w[MAXC], m2_d[MAXC], m2_b[MAXC];
    bit m4_w[MAXC], m4_d[MAXC], m4_b[MAXC];
    int m2_ch[MAXC], m4_ch[MAXC];
    bit exp_w[MAXC], exp_d[MAXC], exp_b[MAXC];
    int exp_ch[MAXC];

    fifo_write_sequencer #(.CNT_W(16), .BURST_W(16), .NCH(2), .SYNC_STG(SYNC_STG),
                           .LOW_CYC(2), .ALIGN_DLY(ALIGN_DLY)) dut2 (
        .clk_in_2x(clk_in_2x), .rst_n(rst_n), .adc_dav(adc_dav), .cfg_we(cfg_we),
        .cfg_period(cfg_period), .cfg_burst(cfg_burst), .arm(arm), .fifo_full(fifo_full),
        .fifo_write(f2_write), .fifo_chan(f2_chan), .busy(f2_busy), .done(f2_done),
        .overflow(f2_ovf), .frame_cnt(f2_fc)
    );

    fifo_write_sequencer #(.CNT_W(16), .BURST_W(16), .NCH(4), .SYNC_STG(SYNC_STG),
                           .LOW_CYC(2), .ALIGN_DLY(ALIGN_DLY)) dut4 (
        .clk_in_2x(clk_in_2x), .rst_n(rst_n), .adc_dav(adc_dav), .cfg_we(cfg_we),
        .cfg_period(cfg_period), .cfg_burst(cfg_burst), .arm(arm), .fifo_full(fifo_full),
        .fifo_write(f4_write), .fifo_chan(f4_chan), .busy(f4_busy), .done(f4_done),
        .overflow(f4_ovf), .frame_cnt(f4_fc)
    );

    always #5 clk_in_2x = ~clk_in_2x;

    always @(posedge clk_in_2x) cyc <= cyc + 1;

    always @(negedge clk_in_2x) begin
        if (cyc < MAXC) begin
            m2_w[cyc] = f2_write; m2_d[cyc] = f2_done; m2_b[cyc] = f2_busy; m2_ch[cyc] = int'(f2_chan);
            m4_w[cyc] = f4_write; m4_d[cyc] = f4_done; m4_b[cyc] = f4_busy; m4_ch[cyc] = int'(f4_chan);
        end
    end

    task automatic step;
        @(posedge clk_in_2x);
        #1;
    endtask

    // kind: 0 = run to completion, 1 = cfg_we at first write of frame sf, 2 = async reset in COUNT before frame sf
    task automatic run_seq(input int nsel, input int per, input int bur, input int fullp,
                           input int full_f, input int full_c, input int hold_hi,
                           input int kind, input int sf, input string name);
        int nch, peff, a, r, s0, lastc, stopc, endc, off, fr, c, och, ofc;
        bit slot, full, ovf_exp, ow, od, ob, oo;
        nch = (nsel == 4) ? 4 : 2;
        peff = (per >= nch + 1) ? per : nch + 1;
        ovf_exp = 1'b0;
        cfg_we = 1'b1; cfg_period = 16'(per); cfg_burst = 16'(bur);
        adc_dav = (hold_hi > 0); fifo_full = 1'b0; arm = 1'b0;
        step;
        cfg_we = 1'b0;
        ob = (nsel == 4) ? f4_busy : f2_busy;
        oo = (nsel == 4) ? f4_ovf : f2_ovf;
        checks++;
        if (ob !== 1'b0) begin errors++; $display("FAIL %s cfg_busy got=%0b exp=0", name, ob); end
        checks++;
        if (oo !== 1'b0) begin errors++; $display("FAIL %s cfg_overflow_clear got=%0b exp=0", name, oo); end
        arm = 1'b1; a = cyc;
        step;
        arm = 1'b0;
        ofc = (nsel == 4) ? int'(f4_fc) : int'(f2_fc);
        checks++;
        if (ofc !== 0) begin errors++; $display("FAIL %s arm_clears_frame_cnt got=%0d exp=0", name, ofc); end

        r = (hold_hi > 0) ? a + hold_hi : a + 4 + int'($urandom_range(0, 5));
        s0 = r + SYNC_STG + 1 + ALIGN_DLY + peff;
        lastc = s0 + (bur - 1) * peff + nch;
        stopc = (kind == 2) ? s0 + sf * peff - 2 : s0 + sf * peff;
        endc = (kind == 0) ? lastc + 3 : stopc + 3;

        while (cyc <= endc) begin
            c = cyc;
            if (hold_hi > 0)
                adc_dav = (c < r - 2) || (c >= r && ((c - r) / 10) % 2 == 0);
            else
                adc_dav = (c >= r) && (((c - r) / 10) % 2 == 0);
            off = (c >= s0) ? (c - s0) % peff : 0;
            fr  = (c >= s0) ? (c - s0) / peff : 0;
            slot = (c >= s0) && (off < nch) && (bur == 0 || fr < bur) && (kind == 0 || c <= stopc);
            full = (slot && fr == full_f && off == full_c) || (int'($urandom_range(0, 99)) < fullp);
            fifo_full = full;
            if (slot && full) ovf_exp = 1'b1;
            cfg_we = (kind == 1 && c == stopc);
            if (kind == 2 && c == stopc + 1) rst_n = 1'b1;
            exp_w[c]  = slot && !full;
            exp_ch[c] = slot ? off : 0;
            exp_d[c]  = (kind == 0) && (bur != 0) && (c == lastc);
            exp_b[c]  = (c > a) && ((kind == 0) ? (c <= lastc) : (kind == 1) ? (c <= stopc) : (c < stopc));
            if (kind == 2 && c == stopc) begin
                ofc = (nsel == 4) ? int'(f4_fc) : int'(f2_fc);
                checks++;
                if (ofc !== sf) begin errors++; $display("FAIL %s pre_reset_frame_cnt got=%0d exp=%0d", name, ofc, sf); end
                #2 rst_n = 1'b0;
                #1;
                ob = (nsel == 4) ? f4_busy : f2_busy;
                ofc = (nsel == 4) ? int'(f4_fc) : int'(f2_fc);
                checks++;
                if (ob !== 1'b0) begin errors++; $display("FAIL %s async_reset_busy got=%0b exp=0", name, ob); end
                checks++;
                if (ofc !== 0) begin errors++; $display("FAIL %s async_reset_frame_cnt got=%0d exp=0", name, ofc); end
            end
            step;
        end
        cfg_we = 1'b0; fifo_full = 1'b0; rst_n = 1'b1;

        for (int k = a + 1; k <= endc; k++) begin
            ow  = (nsel == 4) ? m4_w[k] : m2_w[k];
            od  = (nsel == 4) ? m4_d[k] : m2_d[k];
            ob  = (nsel == 4) ? m4_b[k] : m2_b[k];
            och = (nsel == 4) ? m4_ch[k] : m2_ch[k];
            checks++;
            if (ow !== exp_w[k]) begin errors++; $display("FAIL %s fifo_write t=%0d got=%0b exp=%0b", name, k - a, ow, exp_w[k]); end
            checks++;
            if (och !== exp_ch[k]) begin errors++; $display("FAIL %s fifo_chan t=%0d got=%0d exp=%0d", name, k - a, och, exp_ch[k]); end
            checks++;
            if (od !== exp_d[k]) begin errors++; $display("FAIL %s done t=%0d got=%0b exp=%0b", name, k - a, od, exp_d[k]); end
            checks++;
            if (ob !== exp_b[k]) begin errors++; $display("FAIL %s busy t=%0d got=%0b exp=%0b", name, k - a, ob, exp_b[k]); end
        end

        ofc = (nsel == 4) ? int'(f4_fc) : int'(f2_fc);
        oo  = (nsel == 4) ? f4_ovf : f2_ovf;
        checks++;
        if (ofc !== ((kind == 0) ? bur : (kind == 1) ? sf : 0)) begin
            errors++; $display("FAIL %s final_frame_cnt got=%0d exp=%0d", name, ofc, (kind == 0) ? bur : (kind == 1) ? sf : 0);
        end
        checks++;
        if (oo !== ((kind == 0) ? ovf_exp : 1'b0)) begin
            errors++; $display("FAIL %s final_overflow got=%0b exp=%0b", name, oo, (kind == 0) ? ovf_exp : 1'b0);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; adc_dav = 1'b0; cfg_we = 1'b0; cfg_period = '0; cfg_burst = '0;
        arm = 1'b0; fifo_full = 1'b0;
        step; step;
        checks++; if (f2_write !== 1'b0) begin errors++; $display("FAIL reset f2_write got=%0b exp=0", f2_write); end
        checks++; if (f2_chan !== 1'b0)  begin errors++; $display("FAIL reset f2_chan got=%0d exp=0", f2_chan); end
        checks++; if (f2_busy !== 1'b0)  begin errors++; $display("FAIL reset f2_busy got=%0b exp=0", f2_busy); end
        checks++; if (f2_done !== 1'b0)  begin errors++; $display("FAIL reset f2_done got=%0b exp=0", f2_done); end
        checks++; if (f2_ovf !== 1'b0)   begin errors++; $display("FAIL reset f2_overflow got=%0b exp=0", f2_ovf); end
        checks++; if (f2_fc !== 16'd0)   begin errors++; $display("FAIL reset f2_frame_cnt got=%0d exp=0", f2_fc); end
        checks++; if (f4_write !== 1'b0) begin errors++; $display("FAIL reset f4_write got=%0b exp=0", f4_write); end
        checks++; if (f4_busy !== 1'b0)  begin errors++; $display("FAIL reset f4_busy got=%0b exp=0", f4_busy); end
        checks++; if (f4_fc !== 16'd0)   begin errors++; $display("FAIL reset f4_frame_cnt got=%0d exp=0", f4_fc); end
        rst_n = 1'b1;
        step;
    endtask

    task automatic test_burst;
        run_seq(2, 10, 3, 0, -1, 0, 0, 0, 0, "burst3");
    endtask

    task automatic test_dav_hold;
        run_seq(2, 10, 2, 0, -1, 0, 30, 0, 0, "dav_hold");
    endtask

    task automatic test_overflow;
        run_seq(2, 10, 3, 0, 1, 1, 0, 0, 0, "overflow");
        run_seq(2, 10, 1, 0, -1, 0, 0, 0, 0, "overflow_cleared");
    endtask

    task automatic test_continuous;
        run_seq(4, 1, 0, 0, -1, 0, 0, 1, 6, "continuous");
    endtask

    task automatic test_abort;
        run_seq(2, 10, 4, 0, -1, 0, 0, 1, 2, "cfg_abort");
        run_seq(2, 10, 4, 0, -1, 0, 0, 2, 1, "async_reset");
    endtask

    task automatic test_random;
        int nsel, per, bur, kind;
        for (int i = 0; i < 10; i++) begin
            nsel = ($urandom_range(0, 1) == 1) ? 4 : 2;
            per  = int'($urandom_range(1, 16));
            bur  = int'($urandom_range(1, 4));
            kind = int'($urandom_range(0, 1));
            run_seq(nsel, per, bur, int'($urandom_range(0, 30)), -1, 0, 0, kind,
                    int'($urandom_range(0, bur - 1)), "random");
        end
    endtask

    initial begin
        test_reset;
        test_burst;
        test_dav_hold;
        test_overflow;
        test_continuous;
        test_abort;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
